// File: rtl/load_store_unit.sv
// Data-side memory stage: sized loads/stores to a word-addressed DMEM,
// sub-word stores by read-modify-write, error detection and a ready/valid stall.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LD_REQ, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR
  } state_t;

  state_t            r_state, w_next;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              w_accept;
  logic              w_err;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused_addr;

  // Address bits above the DMEM range are dropped, so accesses wrap.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready & ~RST;
  assign mem_addr  = r_addr[ADDR_W+1:2];

  always_comb begin
    w_err = 1'b0;
    if (req_we) w_err = (req_funct3 > 3'b010);
    else        w_err = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0])          w_err = 1'b1;
      2'b10:   if (req_addr[1:0] != '0)  w_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_W+1:0];
        r_wdata  <= req_wdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) begin
        if (w_err)                        w_next = ERR;
        else if (!req_we)                 w_next = LD_REQ;
        else if (req_funct3[1:0] == 2'b10) w_next = ST_WR;
        else                              w_next = RMW_RD;
      end
      LD_REQ:  w_next = LD_RSP;
      RMW_RD:  w_next = RMW_WR;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // Sub-word store: keep the read word and overwrite only the addressed lane.
  always_comb begin
    w_merge = mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: ;
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  // Strobes and responses are squashed whenever reset is asserted.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      LD_REQ: mem_re = ~RST;
      LD_RSP: begin
        rsp_valid = ~RST;
        rsp_rdata = w_load;
      end
      ST_WR: begin
        mem_we    = ~RST;
        mem_wdata = r_wdata;
        rsp_valid = ~RST;
      end
      RMW_RD: mem_re = ~RST;
      RMW_WR: begin
        mem_we    = ~RST;
        mem_wdata = w_merge;
        rsp_valid = ~RST;
      end
      ERR: begin
        rsp_valid = ~RST;
        rsp_err   = ~RST;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/back-to-back
// sequences, and random traffic checked against a byte-level memory model.
module tb_load_store_unit;
  localparam int ADDR_W = 10;

  logic              CLK = 1'b0;
  logic              RST;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 CLK = ~CLK;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] dmem [0:1023];
  always @(posedge CLK) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: DMEM viewed as a flat little-endian byte array.
  logic [7:0] ref_mem [0:4095];

  function automatic int unsigned ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_illegal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if (we) begin
      if (f3 > 3'd2) return 1'b1;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b1;
    end
    return (addr % ref_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned base = addr % 4096;
    int unsigned sz = ref_size(f3);
    longint v = 0;
    for (int i = 0; i < int'(sz); i++) v += longint'(ref_mem[base + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int unsigned base = (addr % 4096) & ~32'd3;
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned base = addr % 4096;
    for (int i = 0; i < int'(ref_size(f3)); i++) ref_mem[base + i] = 8'(wdata >> (8 * i));
  endtask

  // One transaction; per-cycle observations for cycles 1..4 after accept.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag,
                         output logic [31:0] got_rdata, output bit got_err);
    bit ill = ref_illegal(we, f3, addr);
    logic [4:1] e_re, e_we, e_rv, e_rdy, e_err;
    logic [4:1] o_re, o_we, o_rv, o_rdy, o_err;
    logic [31:0] exp_rdata, exp_word, exp_maddr;
    logic [31:0] o_rdata, o_wdata, o_addr_re, o_addr_we;
    exp_rdata = '0;
    exp_word  = '0;
    exp_maddr = (addr % 4096) / 4;
    if (ill) begin
      e_re = 4'b0000; e_we = 4'b0000; e_rv = 4'b0001; e_rdy = 4'b1110; e_err = 4'b0001;
    end else if (!we) begin
      e_re = 4'b0001; e_we = 4'b0000; e_rv = 4'b0010; e_rdy = 4'b1100; e_err = 4'b0000;
      exp_rdata = ref_load(f3, addr);
    end else if (ref_size(f3) == 4) begin
      e_re = 4'b0000; e_we = 4'b0001; e_rv = 4'b0001; e_rdy = 4'b1110; e_err = 4'b0000;
      ref_store(f3, addr, wdata);
      exp_word = ref_word(addr);
    end else begin
      e_re = 4'b0001; e_we = 4'b0010; e_rv = 4'b0010; e_rdy = 4'b1100; e_err = 4'b0000;
      ref_store(f3, addr, wdata);
      exp_word = ref_word(addr);
    end

    @(negedge CLK);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    chk({tag, " ready_at_accept"}, 32'(req_ready), 32'd1);
    @(posedge CLK);
    o_re = '0; o_we = '0; o_rv = '0; o_rdy = '0; o_err = '0;
    o_rdata = '0; o_wdata = '0; o_addr_re = '0; o_addr_we = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (k == 1) req_valid = 1'b0;
      o_re[k]  = mem_re;
      o_we[k]  = mem_we;
      o_rv[k]  = rsp_valid;
      o_rdy[k] = req_ready;
      o_err[k] = rsp_err & rsp_valid;
      if (e_rv[k]) o_rdata = rsp_rdata;
      if (e_we[k]) begin o_wdata = mem_wdata; o_addr_we = 32'(mem_addr); end
      if (e_re[k]) o_addr_re = 32'(mem_addr);
    end
    chk({tag, " mem_re_cycles"},    32'(o_re),  32'(e_re));
    chk({tag, " mem_we_cycles"},    32'(o_we),  32'(e_we));
    chk({tag, " rsp_valid_cycles"}, 32'(o_rv),  32'(e_rv));
    chk({tag, " ready_cycles"},     32'(o_rdy), 32'(e_rdy));
    chk({tag, " rsp_err_cycles"},   32'(o_err), 32'(e_err));
    chk({tag, " rsp_rdata"},        o_rdata,    exp_rdata);
    if (e_we != '0) begin
      chk({tag, " mem_wdata"},   o_wdata,   exp_word);
      chk({tag, " mem_addr_wr"}, o_addr_we, exp_maddr);
    end
    if (e_re != '0) chk({tag, " mem_addr_rd"}, o_addr_re, exp_maddr);
    got_rdata = o_rdata;
    got_err   = (o_err != '0);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, got, a;
    bit          gerr, we;
    logic [2:0]  f3;
    int          n_acc, n_rsp;
    int          acc [4];
    logic        rdy_hist [20];

    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      w = (i == 16) ? 32'h8081_7F01 : $urandom;
      dmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(w >> (8 * b));
    end

    tbl[0]  = '{1'b0, 3'b000, 32'h42,   32'h0,         1'b0, 32'hFFFF_FF81};
    tbl[1]  = '{1'b0, 3'b100, 32'h42,   32'h0,         1'b0, 32'h0000_0081};
    tbl[2]  = '{1'b0, 3'b001, 32'h42,   32'h0,         1'b0, 32'hFFFF_8081};
    tbl[3]  = '{1'b0, 3'b101, 32'h42,   32'h0,         1'b0, 32'h0000_8081};
    tbl[4]  = '{1'b0, 3'b000, 32'h41,   32'h0,         1'b0, 32'h0000_007F};
    tbl[5]  = '{1'b0, 3'b010, 32'h40,   32'h0,         1'b0, 32'h8081_7F01};
    tbl[6]  = '{1'b1, 3'b000, 32'h43,   32'h1234_56AA, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 3'b001, 32'h40,   32'hFFFF_1234, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 3'b010, 32'h40,   32'h0,         1'b0, 32'hAA81_1234};
    tbl[9]  = '{1'b1, 3'b010, 32'h44,   32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h44,   32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[11] = '{1'b0, 3'b010, 32'h41,   32'h0,         1'b1, 32'h0};
    tbl[12] = '{1'b1, 3'b001, 32'h43,   32'h5555_5555, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 3'b011, 32'h40,   32'h0,         1'b1, 32'h0};
    tbl[14] = '{1'b0, 3'b010, 32'h1040, 32'h0,         1'b0, 32'hAA81_1234};
    tbl[15] = '{1'b0, 3'b101, 32'h46,   32'h0,         1'b0, 32'h0000_DEAD};
    tbl[16] = '{1'b0, 3'b000, 32'h47,   32'h0,         1'b0, 32'hFFFF_FFDE};
    tbl[17] = '{1'b1, 3'b011, 32'h40,   32'h0,         1'b1, 32'h0};

    // Reset state, and a request during reset must not be accepted.
    repeat (2) @(negedge CLK);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_err",   32'(rsp_err),   32'd0);
    chk("rst rsp_rdata", rsp_rdata,      32'd0);
    chk("rst mem_re",    32'(mem_re),    32'd0);
    chk("rst mem_we",    32'(mem_we),    32'd0);
    chk("rst mem_wdata", mem_wdata,      32'd0);
    chk("rst mem_addr",  32'(mem_addr),  32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge CLK);
    req_valid = 1'b0; RST = 1'b0;
    @(negedge CLK);
    chk("rst_req not_accepted ready", 32'(req_ready), 32'd1);
    chk("rst_req not_accepted mem_re", 32'(mem_re), 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, $sformatf("vec%0d", i), got, gerr);
      chk($sformatf("vec%0d table_rdata", i), got, tbl[i].rdata);
      chk($sformatf("vec%0d table_err", i), 32'(gerr), 32'(tbl[i].err));
    end

    // Reset landing on the write cycle of a byte store.
    @(negedge CLK);
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h40; req_wdata = 32'h0000_0055;
    req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("rmw_rst mem_re", 32'(mem_re), 32'd1);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("rmw_rst mem_we",    32'(mem_we),    32'd0);
    chk("rmw_rst rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rmw_rst ready_after", 32'(req_ready), 32'd1);
    chk("rmw_rst dmem_word", dmem[16], ref_word(32'h40));

    // Four back-to-back word loads with req_valid held high.
    n_acc = 0; n_rsp = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) req_valid = 1'b1;
      if (n_acc == 4) req_valid = 1'b0;
      rdy_hist[cyc] = req_ready;
      if (rsp_valid) begin
        n_rsp++;
        chk("b2b rsp_rdata", rsp_rdata, ref_load(3'b010, 32'h40));
      end
      if (req_valid && req_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
      end
    end
    req_valid = 1'b0;
    chk("b2b accepts", 32'(n_acc), 32'd4);
    chk("b2b responses", 32'(n_rsp), 32'd4);
    for (int i = 1; i < n_acc; i++) chk($sformatf("b2b spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd3);
    for (int i = 0; i < n_acc; i++) begin
      if (acc[i] + 2 < 20) begin
        chk($sformatf("b2b ready+1_%0d", i), 32'(rdy_hist[acc[i] + 1]), 32'd0);
        chk($sformatf("b2b ready+2_%0d", i), 32'(rdy_hist[acc[i] + 2]), 32'd0);
      end
    end

    // Random traffic over the low words, with wrapping high address bits.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_txn(we, f3, a, $urandom, $sformatf("rnd%0d", n), got, gerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side memory stage between the RISC-V core's execute stage and the 32-bit word-addressed data memory (DMEM). Accepts one load or store per transaction, handles byte/halfword/word sizing, and sign- or zero-extends load data. Implements sub-word stores as read-modify-write, because DMEM has no byte enables. Detects misaligned and illegal accesses and stalls the core through a ready/valid handshake.

## Interface
- ADDR_W, 10, DMEM word-address width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present; core holds all req_* stable until accepted.
- req_ready  out  1  unit can accept; a transfer occurs when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned or illegal funct3.
- mem_addr  out  ADDR_W  DMEM word address = req_addr[ADDR_W+1:2].
- mem_re  out  1  DMEM read strobe.
- mem_we  out  1  DMEM write strobe.
- mem_wdata  out  32  DMEM write word.
- mem_rdata  in  32  DMEM read data, valid the cycle after mem_re (1-cycle synchronous read).

## Operation
- States: IDLE, LD_REQ, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR.
- IDLE: req_ready=1. On accept, latch the request and decode it:
  - error → ERR;
  - load → LD_REQ;
  - SW → ST_WR;
  - SB/SH → RMW_RD.
- Error conditions:
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010;
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0.
- LD_REQ: mem_re=1 → LD_RSP.
- LD_RSP: rsp_valid=1, rsp_rdata = selected lane of mem_rdata, extended → IDLE.
  - Lane selection: byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ST_WR: mem_we=1, mem_wdata=req_wdata, rsp_valid=1 → IDLE.
- RMW_RD: mem_re=1 → RMW_WR.
- RMW_WR: mem_we=1, rsp_valid=1 → IDLE.
  - mem_wdata = mem_rdata with the target lane replaced by req_wdata[7:0] (SB) or req_wdata[15:0] (SH).
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0; no mem_re or mem_we is issued for the transaction → IDLE.
- req_addr bits above ADDR_W+1 are ignored, so addresses wrap modulo DMEM size.
- mem_addr is driven from the latched address in every non-IDLE state.

## Timing
- Cycle 0 = accept cycle. All strobes and responses are decoded from registered state; none are combinational from req_*.
- Load: mem_re in cycle 1; rsp_valid in cycle 2; req_ready again in cycle 3.
- SW: mem_we and rsp_valid in cycle 1; ready in cycle 2.
- SB/SH: mem_re in cycle 1; mem_we and rsp_valid in cycle 2; ready in cycle 3.
- Error: rsp_valid and rsp_err in cycle 1; ready in cycle 2.
- No pipelining: at most one transaction in flight. req_ready=0 in every non-IDLE state.
- mem_re and mem_we are never both high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0.
- RST gating: mem_we, mem_re and rsp_valid are gated with !RST. If RST is asserted in any cycle, including mid-RMW, there is no DMEM write and no response that cycle; IDLE follows on the next edge.
- A request presented while RST=1 is not accepted.

## Test plan
Preload DMEM word 0x10 (byte address 0x40) = 0x8081_7F01.

- Loads at 0x42 → rsp_valid exactly 2 cycles after accept, mem_re exactly 1 cycle after accept:
  - LB → 0xFFFF_FF81;
  - LBU → 0x0000_0081;
  - LH → 0xFFFF_8081;
  - LHU → 0x0000_8081;
  - LB 0x41 → 0x0000_007F;
  - LW 0x40 → 0x8081_7F01.
- SB 0x43, wdata 0x1234_56AA → mem_re in cycle 1, mem_we in cycle 2 with mem_wdata=0xAA81_7F01. Then SH 0x40, wdata 0xFFFF_1234 → word reads back 0xAA81_1234.
- SW 0x44, 0xDEAD_BEEF → mem_we in cycle 1, mem_addr=0x11, rsp_valid in cycle 1, req_ready high in cycle 2.
- Each of the following → rsp_err=1 with rsp_valid in cycle 1, rsp_rdata=0, and mem_re=mem_we=0 throughout:
  - LW 0x41;
  - SH 0x43;
  - load funct3=011.
- SB 0x40 with RST asserted during the RMW_WR cycle → mem_we stays 0, DMEM word unchanged, no rsp_valid, req_ready=1 in the following cycle.
- req_valid held high for 4 consecutive LW → accepts spaced 3 cycles apart; req_ready=0 in the two cycles after each accept. Address 0x1040 with ADDR_W=10 → mem_addr=0x010.
